// File: rtl/probe_hook_if.sv
// Bundle of the upstream hook channel and the per-probe requester signals.
// The master modport is the arbiter's view of this bundle; the slave modport is the
// view of whatever drives the hook and the probes.
interface probe_hook_if #(
  parameter int NUM_PROBES = 4
);
  logic                        ACK;
  logic [31:0]                 DATAUP;
  logic                        DATAVALID;
  logic                        DELAY;
  logic                        CMDEN;
  logic [18:0]                 CMD;
  logic                        CTIMER;
  logic [NUM_PROBES-1:0]       p_valid;
  logic [32*NUM_PROBES-1:0]    p_data;
  logic [NUM_PROBES-1:0]       p_last;
  logic [NUM_PROBES-1:0]       p_ready;
  logic [NUM_PROBES-1:0]       p_en;
  logic [NUM_PROBES-1:0]       p_cmden;
  logic [7:0]                  p_cmd;
  logic                        p_ctimer;

  modport master (
    input  ACK, CMDEN, CMD, CTIMER, p_valid, p_data, p_last,
    output DATAUP, DATAVALID, DELAY, p_ready, p_en, p_cmden, p_cmd, p_ctimer
  );

  modport slave (
    output ACK, CMDEN, CMD, CTIMER, p_valid, p_data, p_last,
    input  DATAUP, DATAVALID, DELAY, p_ready, p_en, p_cmden, p_cmd, p_ctimer
  );
endinterface

// File: rtl/probe_hook_arbiter.sv
// Shares the single upstream probe channel between NUM_PROBES requesters.
// Round-robin grant per burst, command decode for enables and command forwarding.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | arbitration cycle; no upstream word, picks next enabled requester
//  S_BURST | granted requester streams words until last or MAX_BURST words
module probe_hook_arbiter #(
  parameter int NUM_PROBES = 4,
  parameter int MAX_BURST  = 16
) (
  input  logic          UCLK,
  input  logic          URST,
  probe_hook_if.master  bus
);

  localparam int         IW       = (NUM_PROBES > 1) ? $clog2(NUM_PROBES) : 1;
  localparam logic [7:0] CNT_LAST = 8'(MAX_BURST - 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           grant_q, grant_d;
  logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [7:0]              burst_cnt_q, burst_cnt_d;
  logic [NUM_PROBES-1:0]   p_en_q, p_en_d;
  logic [NUM_PROBES-1:0]   p_cmden_q, p_cmden_d;
  logic [7:0]              p_cmd_q, p_cmd_d;

  logic [NUM_PROBES-1:0]   req;
  logic [NUM_PROBES-1:0]   grant_oh;
  logic [NUM_PROBES-1:0]   idx_sel;
  logic [31:0]             word_sel;
  logic                    valid_sel;
  logic                    last_sel;
  logic                    accept;
  logic                    found;
  logic [IW-1:0]           winner;

  // Arbitration uses the enable mask as it stood before any command in this cycle.
  assign req    = bus.p_valid & p_en_q;
  assign accept = (state_q == S_BURST) && valid_sel && bus.ACK;

  // State and configuration registers, all cleared asynchronously.
  always_ff @(posedge UCLK or posedge URST) begin
    if (URST) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= IW'(NUM_PROBES - 1);
      burst_cnt_q <= '0;
      p_en_q      <= '0;
      p_cmden_q   <= '0;
      p_cmd_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      p_en_q      <= p_en_d;
      p_cmden_q   <= p_cmden_d;
      p_cmd_q     <= p_cmd_d;
    end
  end

  // Mux the granted requester's word, valid and last; also its one-hot grant.
  always_comb begin
    word_sel  = '0;
    valid_sel = 1'b0;
    last_sel  = 1'b0;
    grant_oh  = '0;
    for (int i = 0; i < NUM_PROBES; i++) begin
      if (grant_q == IW'(i)) begin
        word_sel    = bus.p_data[32*i +: 32];
        valid_sel   = bus.p_valid[i];
        last_sel    = bus.p_last[i];
        grant_oh[i] = 1'b1;
      end
    end
  end

  // Round-robin search starting one past the previous winner, wrapping modulo NUM_PROBES.
  always_comb begin
    logic [IW:0]   cand_w;
    logic [IW-1:0] cand;
    found  = 1'b0;
    winner = rr_ptr_q;
    cand_w = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_PROBES; k++) begin
      cand_w = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand_w >= (IW+1)'(NUM_PROBES)) begin
        cand_w = cand_w - (IW+1)'(NUM_PROBES);
      end
      cand = cand_w[IW-1:0];
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Command decode: indexed ops only act on an in-range probe index.
  always_comb begin
    p_en_d    = p_en_q;
    p_cmden_d = '0;
    p_cmd_d   = p_cmd_q;
    idx_sel   = '0;
    for (int i = 0; i < NUM_PROBES; i++) begin
      idx_sel[i] = (bus.CMD[15:8] == 8'(i));
    end
    if (bus.CMDEN) begin
      case (bus.CMD[18:16])
        3'd1: p_en_d = p_en_q | idx_sel;
        3'd2: p_en_d = p_en_q & ~idx_sel;
        3'd3: begin
          p_cmden_d = idx_sel;
          if (|idx_sel) p_cmd_d = bus.CMD[7:0];
        end
        3'd4: p_en_d = '1;
        3'd5: p_en_d = '0;
        default: ;
      endcase
    end
  end

  // Next-state: grant on a pending request, release on last word or burst cap.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d     = winner;
          rr_ptr_d    = winner;
          burst_cnt_d = '0;
          state_d     = S_BURST;
        end
      end
      S_BURST: begin
        if (accept) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (last_sel || (burst_cnt_q == CNT_LAST)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: zero-latency handshake from the registered grant.
  always_comb begin
    bus.DATAVALID = 1'b0;
    bus.DATAUP    = '0;
    bus.p_ready   = '0;
    bus.DELAY     = 1'b0;
    if (state_q == S_BURST) begin
      bus.DATAVALID = valid_sel;
      bus.DATAUP    = valid_sel ? word_sel : 32'd0;
      bus.p_ready   = accept ? grant_oh : '0;
      bus.DELAY     = !(valid_sel && bus.ACK);
    end else begin
      bus.DELAY     = |req;
    end
  end

  assign bus.p_en     = p_en_q;
  assign bus.p_cmden  = p_cmden_q;
  assign bus.p_cmd    = p_cmd_q;
  assign bus.p_ctimer = bus.CTIMER;

endmodule

// File: tb/tb_probe_hook_arbiter.sv
// Scoreboard bench for probe_hook_arbiter: per-probe expected word queues filled at
// stimulus time, a negedge monitor that tracks grants with a burst-level reference model.
module tb_probe_hook_arbiter;
  localparam int N  = 4;
  localparam int MB = 16;

  logic clk;
  logic rst;

  probe_hook_if #(.NUM_PROBES(N)) bus ();

  probe_hook_arbiter #(.NUM_PROBES(N), .MAX_BURST(MB)) dut (
    .UCLK (clk),
    .URST (rst),
    .bus  (bus.master)
  );

  // probe-side drive, packed onto the bus
  logic [31:0] pd  [N];
  logic        pvb [N];
  logic        plb [N];
  assign bus.p_data  = {pd[3], pd[2], pd[1], pd[0]};
  assign bus.p_valid = {pvb[3], pvb[2], pvb[1], pvb[0]};
  assign bus.p_last  = {plb[3], plb[2], plb[1], plb[0]};

  // source queues (what each probe still has to send) and scoreboard queues
  logic [31:0] src_d [N][$];
  bit          src_l [N][$];
  logic [31:0] exp_q [N][$];

  int checks;
  int errors;
  int ack_pct, valid_pct, cmd_pct;
  bit          pend_v;
  logic [18:0] pend_c;

  // reference model state (burst-level)
  int         m_owner;   // -1: arbitration cycle, else granted probe
  int         m_rr;
  int         m_cnt;
  bit         m_en    [N];
  bit         m_cmden [N];
  logic [7:0] m_cmd;

  int          dv_cycles;
  int          acc_order[$];
  bit          first_seen;
  logic [N-1:0] first_rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model and output checks, sampled at the falling edge.
  always @(negedge clk) begin : mon
    logic [N-1:0] req_v, e_rdy, en_v, cmden_v;
    bit           e_dv, e_del, acc;
    logic [31:0]  e_data;
    bit           nx_cmden [N];
    int           idx, c;
    logic [2:0]   op;
    if (rst) begin
      m_owner = -1; m_rr = N-1; m_cnt = 0; m_cmd = '0;
      for (int i = 0; i < N; i++) begin m_en[i] = 0; m_cmden[i] = 0; end
    end else begin
      req_v = '0; en_v = '0; cmden_v = '0; e_rdy = '0;
      e_dv = 0; e_del = 0; acc = 0; e_data = '0;
      for (int i = 0; i < N; i++) begin
        if (m_en[i]) en_v = en_v | (N'(1) << i);
        if (m_cmden[i]) cmden_v = cmden_v | (N'(1) << i);
        if (m_en[i] && pvb[i]) req_v = req_v | (N'(1) << i);
      end
      if (m_owner < 0) begin
        e_del = (req_v != '0);
      end else begin
        e_dv  = pvb[m_owner];
        acc   = e_dv && bus.ACK;
        e_del = !acc;
        if (acc) e_rdy = N'(1) << m_owner;
        if (e_dv) begin
          if (exp_q[m_owner].size() > 0) e_data = exp_q[m_owner][0];
          else chk("sb_underflow", 32'd0, 32'd1);
        end
      end
      chk("datavalid", bus.DATAVALID, e_dv);
      chk("dataup",    bus.DATAUP,    e_data);
      chk("p_ready",   bus.p_ready,   e_rdy);
      chk("delay",     bus.DELAY,     e_del);
      chk("p_en",      bus.p_en,      en_v);
      chk("p_cmden",   bus.p_cmden,   cmden_v);
      chk("p_cmd",     bus.p_cmd,     m_cmd);
      chk("p_ctimer",  bus.p_ctimer,  bus.CTIMER);

      if (bus.DATAVALID) dv_cycles++;
      if (bus.DATAVALID && bus.ACK) begin
        for (int j = 0; j < N; j++) if (bus.p_ready == (N'(1) << j)) acc_order.push_back(j);
        if (!first_seen) begin first_seen = 1; first_rdy = bus.p_ready; end
      end

      // advance model by one clock
      if (m_owner < 0) begin
        for (int off = 1; off <= N; off++) begin
          c = (m_rr + off) % N;
          if (m_owner < 0 && req_v[c[1:0]]) begin
            m_owner = c; m_rr = c; m_cnt = 0;
          end
        end
      end else if (acc) begin
        void'(exp_q[m_owner].pop_front());
        void'(src_d[m_owner].pop_front());
        if (src_l[m_owner].size() > 0 && src_l[m_owner].pop_front()) m_owner = -1;
        else begin
          m_cnt++;
          if (m_cnt == MB) m_owner = -1;
        end
      end
      for (int i = 0; i < N; i++) nx_cmden[i] = 0;
      if (bus.CMDEN) begin
        op  = bus.CMD[18:16];
        idx = int'(bus.CMD[15:8]);
        case (op)
          3'd1: if (idx < N) m_en[idx] = 1;
          3'd2: if (idx < N) m_en[idx] = 0;
          3'd3: if (idx < N) begin nx_cmden[idx] = 1; m_cmd = bus.CMD[7:0]; end
          3'd4: for (int i = 0; i < N; i++) m_en[i] = 1;
          3'd5: for (int i = 0; i < N; i++) m_en[i] = 0;
          default: ;
        endcase
      end
      for (int i = 0; i < N; i++) m_cmden[i] = nx_cmden[i];
    end
  end

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (src_d[i].size() > 0 && ($urandom_range(99) < valid_pct)) begin
        pvb[i] = 1'b1; pd[i] = src_d[i][0]; plb[i] = src_l[i][0];
      end else begin
        pvb[i] = 1'b0; pd[i] = $urandom; plb[i] = 1'($urandom);
      end
    end
    bus.ACK    = ($urandom_range(99) < ack_pct);
    bus.CTIMER = 1'($urandom);
    if (pend_v) begin
      bus.CMDEN = 1'b1; bus.CMD = pend_c; pend_v = 0;
    end else if ($urandom_range(99) < cmd_pct) begin
      bus.CMDEN = 1'b1;
      bus.CMD   = {3'($urandom_range(7)), 8'($urandom_range(15)), 8'($urandom)};
    end else begin
      bus.CMDEN = 1'b0; bus.CMD = 19'($urandom);
    end
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] idx, input logic [7:0] arg);
    pend_v = 1; pend_c = {op, idx, arg};
    step();
  endtask

  task automatic push_word(input int p, input logic [31:0] d, input bit last);
    src_d[p].push_back(d); src_l[p].push_back(last); exp_q[p].push_back(d);
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < N; i++) if (src_d[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin src_d[i].delete(); src_l[i].delete(); exp_q[i].delete(); end
  endtask

  task automatic drain(input int budget, input bit need_idle);
    int n = 0;
    while (!(srcs_empty() && (!need_idle || m_owner < 0))) begin
      step(); n++;
      if (n > budget) begin
        checks++; errors++;
        $display("FAIL drain_timeout actual=%0d required<=%0d", n, budget);
        break;
      end
    end
    step(); step();
  endtask

  task automatic reset_dut();
    @(posedge clk); #3;
    rst = 1'b1;
    clear_queues();
    step(); step();
    rst = 1'b0;
  endtask

  initial begin : main
    logic [31:0] w [8];
    int bad;
    checks = 0; errors = 0; pend_v = 0; pend_c = '0;
    ack_pct = 100; valid_pct = 100; cmd_pct = 0;
    dv_cycles = 0; first_seen = 0; first_rdy = '0;
    m_owner = -1; m_rr = N-1; m_cnt = 0; m_cmd = '0;
    for (int i = 0; i < N; i++) begin pvb[i] = 0; pd[i] = '0; plb[i] = 0; m_en[i] = 0; m_cmden[i] = 0; end
    bus.ACK = 0; bus.CMDEN = 0; bus.CMD = '0; bus.CTIMER = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_datavalid", bus.DATAVALID, 0);
    chk("rst_dataup",    bus.DATAUP,    0);
    chk("rst_p_ready",   bus.p_ready,   0);
    chk("rst_delay",     bus.DELAY,     0);
    chk("rst_p_en",      bus.p_en,      0);
    chk("rst_p_cmden",   bus.p_cmden,   0);
    chk("rst_p_cmd",     bus.p_cmd,     0);
    rst = 1'b0;

    // enable all, probes 0 and 2 each send one last word
    send_cmd(3'd4, 8'd0, 8'd0);
    step();
    acc_order.delete(); dv_cycles = 0;
    push_word(0, 32'h0000_A000, 1);
    push_word(2, 32'h0002_A002, 1);
    drain(200, 1);
    chk("t1_dv_cycles", dv_cycles, 2);
    chk("t1_count", acc_order.size(), 2);
    if (acc_order.size() == 2) begin
      chk("t1_first",  acc_order[0], 0);
      chk("t1_second", acc_order[1], 2);
    end

    // all four probes with single-word bursts: strict rotation from probe 0
    reset_dut();
    send_cmd(3'd4, 8'd0, 8'd0);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) push_word(i, {8'(i), 8'(k), 16'h5150}, 1);
    step();
    acc_order.delete();
    drain(400, 1);
    chk("t2_count", acc_order.size(), 12);
    for (int k = 0; k < 5; k++)
      if (k < acc_order.size()) chk("t2_order", acc_order[k], k % N);

    // ACK held low five cycles mid-burst
    for (int k = 0; k < 8; k++) begin w[k] = $urandom; push_word(3, w[k], k == 7); end
    ack_pct = 100;
    step(); step(); step();
    ack_pct = 0;
    for (int k = 0; k < 5; k++) begin
      step(); #1;
      chk("t4_dataup_hold", bus.DATAUP, w[2]);
      chk("t4_delay", bus.DELAY, 1);
      chk("t4_p_ready", bus.p_ready, 0);
    end
    ack_pct = 100;
    drain(200, 1);

    // command forwarding, valid and out-of-range index
    send_cmd(3'd3, 8'h02, 8'hA5);
    step(); #1;
    chk("t5_p_cmden", bus.p_cmden, 4'b0100);
    chk("t5_p_cmd",   bus.p_cmd,   8'hA5);
    send_cmd(3'd3, 8'h09, 8'h3C);
    step(); #1;
    chk("t5_idx9_cmden", bus.p_cmden, 4'b0000);
    chk("t5_idx9_cmd",   bus.p_cmd,   8'hA5);

    // randomized traffic, commands, ACK and valid gaps
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 4; b++) begin
        int len;
        len = $urandom_range(1, 20);
        for (int k = 0; k < len; k++) push_word(i, $urandom, k == len-1);
      end
    ack_pct = 70; valid_pct = 80; cmd_pct = 10;
    repeat (800) step();
    cmd_pct = 0;
    send_cmd(3'd4, 8'd0, 8'd0);
    drain(5000, 1);
    ack_pct = 100; valid_pct = 100;

    // probe 1 streams 20 words without last: cap at 16 then re-grant
    acc_order.delete();
    for (int k = 0; k < 20; k++) push_word(1, 32'h1000_0000 + k, 0);
    drain(300, 0);
    chk("t3_count", acc_order.size(), 20);
    bad = 0;
    foreach (acc_order[k]) if (acc_order[k] != 1) bad++;
    chk("t3_all_probe1", bad, 0);

    // asynchronous reset while a word is presented
    for (int k = 0; k < 3; k++) push_word(1, 32'h1100_0000 + k, k == 2);
    ack_pct = 0;
    step(); #1;
    chk("t6_pre_dv", bus.DATAVALID, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_dv",      bus.DATAVALID, 0);
    chk("t6_rst_p_ready", bus.p_ready,   0);
    chk("t6_rst_p_en",    bus.p_en,      0);
    chk("t6_rst_dataup",  bus.DATAUP,    0);
    clear_queues();
    step(); step();
    rst = 1'b0;
    ack_pct = 100;
    first_seen = 0;
    send_cmd(3'd4, 8'd0, 8'd0);
    push_word(3, 32'h3333_0003, 1);
    push_word(0, 32'h0000_0F00, 1);
    step();
    drain(200, 1);
    chk("t6_first_grant", first_rdy, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
